gpio_serial_cfg_loader: RTL and testbench

- Sequences the user-project pad configuration chain.
- After a start request, reads one CFG_BITS-wide configuration word per user pad from housekeeping storage through a synchronous read port. The word carries dm[2:0], slow_sel, vtrip_sel, ib_mode_sel, inp_dis, holdover, analog_en/sel/pol, oeb and mgmt_ena.
- Shifts all words MSB-first into the daisy-chained per-pad control blocks, then pulses serial_load so every pad latches its new configuration at once.
- Sits in the management/housekeeping domain (vccd), beside the padframe.

---
 rtl/gpio_cfg_pkg.sv | 58 +++++
 rtl/gpio_cfg_clkdiv.sv | 27 ++
 rtl/gpio_serial_cfg_loader.sv | 129 ++++++++++++
 tb/tb_gpio_serial_cfg_loader.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cfg_pkg.sv
// Shared types and constants for the user-pad configuration chain loader.
// Word layout helpers let software-side and bench code build cfg words by field.
package gpio_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_SETUP,
    ST_HIGH,
    ST_LOAD
  } cfg_state_e;

  localparam int CFG_BITS_DEF = 13;

  localparam int MGMT_ENA    = 0;
  localparam int OEB         = 1;
  localparam int HOLDOVER    = 2;
  localparam int INP_DIS     = 3;
  localparam int IB_MODE_SEL = 4;
  localparam int ANALOG_EN   = 5;
  localparam int ANALOG_SEL  = 6;
  localparam int ANALOG_POL  = 7;
  localparam int SLOW_SEL    = 8;
  localparam int VTRIP_SEL   = 9;
  localparam int DM_LSB      = 10;
  localparam int DM_MSB      = 12;

  function automatic logic [CFG_BITS_DEF-1:0] pack_cfg(
    input logic [2:0] dm,
    input logic       slow_sel,
    input logic       vtrip_sel,
    input logic       ib_mode_sel,
    input logic       inp_dis,
    input logic       holdover,
    input logic       analog_en,
    input logic       analog_sel,
    input logic       analog_pol,
    input logic       oeb,
    input logic       mgmt_ena
  );
    logic [CFG_BITS_DEF-1:0] w;
    w                 = '0;
    w[DM_MSB:DM_LSB]  = dm;
    w[SLOW_SEL]       = slow_sel;
    w[VTRIP_SEL]      = vtrip_sel;
    w[IB_MODE_SEL]    = ib_mode_sel;
    w[INP_DIS]        = inp_dis;
    w[HOLDOVER]       = holdover;
    w[ANALOG_EN]      = analog_en;
    w[ANALOG_SEL]     = analog_sel;
    w[ANALOG_POL]     = analog_pol;
    w[OEB]            = oeb;
    w[MGMT_ENA]       = mgmt_ena;
    return w;
  endfunction

endpackage

// File: rtl/gpio_cfg_clkdiv.sv
// Half-period tick counter: reload on state entry, tick after DIV cycles in the state.
module gpio_cfg_clkdiv #(
  parameter int DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic reload,
  output logic tick
);

  localparam int CW = $clog2(DIV + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (reload) begin
      cnt <= CW'(DIV - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/gpio_serial_cfg_loader.sv
// Reads one config word per user pad and shifts them MSB-first, highest pad first,
// into the pad control daisy chain, then strobes serial_load so all pads latch together.
module gpio_serial_cfg_loader
  import gpio_cfg_pkg::*;
#(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = CFG_BITS_DEF,
  parameter int CLK_DIV  = 2,
  parameter int AW       = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       cfg_addr,
  output logic                cfg_rd,
  input  logic [CFG_BITS-1:0] cfg_data,
  output logic                serial_clock,
  output logic                serial_data,
  output logic                serial_load
);

  localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

  cfg_state_e          state, state_nxt;
  logic [AW-1:0]       pad_idx, pad_nxt;
  logic [BW-1:0]       bit_idx, bit_nxt;
  logic [CFG_BITS-1:0] shreg, shreg_nxt;
  logic                tick;
  logic                done_nxt;
  logic                sdata_nxt;

  gpio_cfg_clkdiv #(.DIV(CLK_DIV)) u_div (
    .clock  (clock),
    .reset  (reset),
    .reload (state_nxt != state),
    .tick   (tick)
  );

  always_comb begin
    state_nxt = state;
    pad_nxt   = pad_idx;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    done_nxt  = 1'b0;
    if (state == ST_IDLE) begin
      // abort outranks a same-cycle start
      if (start && !abort) begin
        state_nxt = ST_FETCH;
        pad_nxt   = AW'(NUM_PADS - 1);
        bit_nxt   = BW'(CFG_BITS - 1);
      end
    end else if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_FETCH:   state_nxt = ST_CAPTURE;
        ST_CAPTURE: begin
          state_nxt = ST_SETUP;
          shreg_nxt = cfg_data;
        end
        ST_SETUP:   if (tick) state_nxt = ST_HIGH;
        ST_HIGH: begin
          if (tick) begin
            shreg_nxt = shreg << 1;
            if (bit_idx != '0) begin
              bit_nxt   = bit_idx - BW'(1);
              state_nxt = ST_SETUP;
            end else if (pad_idx != '0) begin
              pad_nxt   = pad_idx - AW'(1);
              bit_nxt   = BW'(CFG_BITS - 1);
              state_nxt = ST_FETCH;
            end else begin
              state_nxt = ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (tick) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    // Data only moves when a new SETUP is entered, i.e. while the chain clock is low.
    sdata_nxt = 1'b0;
    if (state_nxt == ST_HIGH || (state_nxt == ST_SETUP && state == ST_SETUP)) begin
      sdata_nxt = serial_data;
    end else if (state_nxt == ST_SETUP) begin
      sdata_nxt = shreg_nxt[CFG_BITS-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      pad_idx      <= '0;
      bit_idx      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_rd       <= 1'b0;
      cfg_addr     <= '0;
      serial_clock <= 1'b0;
      serial_data  <= 1'b0;
      serial_load  <= 1'b0;
    end else begin
      state        <= state_nxt;
      pad_idx      <= pad_nxt;
      bit_idx      <= bit_nxt;
      busy         <= (state_nxt != ST_IDLE);
      done         <= done_nxt;
      cfg_rd       <= (state_nxt == ST_FETCH);
      if (state_nxt == ST_FETCH) cfg_addr <= pad_nxt;
      serial_clock <= (state_nxt == ST_HIGH);
      serial_data  <= sdata_nxt;
      serial_load  <= (state_nxt == ST_LOAD);
    end
  end

  always_ff @(posedge clock) begin
    shreg <= shreg_nxt;
  end

endmodule

// File: tb/tb_gpio_serial_cfg_loader.sv
// Bench for gpio_serial_cfg_loader: timeline reference model, chain model, protocol
// monitor, plus a small-parameter instance pinned against hand-derived values.
module tb_gpio_serial_cfg_loader;
  import gpio_cfg_pkg::*;

  localparam int NP    = 38;
  localparam int CB    = 13;
  localparam int CD    = 2;
  localparam int P     = 2 + 2 * CB * CD;
  localparam int TOTAL = NP * P + CD;
  localparam int SNP   = 2;
  localparam int SCB   = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, start, abort;
  logic          busy, done, cfg_rd, serial_clock, serial_data, serial_load;
  logic [5:0]    cfg_addr;
  logic [CB-1:0] cfg_data;
  logic [CB-1:0] mem [NP];

  logic           s_start, s_abort;
  logic           s_busy, s_done, s_cfg_rd, s_sclk, s_sd, s_load;
  logic [1:0]     s_cfg_addr;
  logic [SCB-1:0] s_cfg_data;
  logic [SCB-1:0] s_mem [SNP];

  gpio_serial_cfg_loader dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .cfg_addr(cfg_addr), .cfg_rd(cfg_rd),
    .cfg_data(cfg_data), .serial_clock(serial_clock),
    .serial_data(serial_data), .serial_load(serial_load)
  );

  gpio_serial_cfg_loader #(.NUM_PADS(SNP), .CFG_BITS(SCB), .CLK_DIV(1), .AW(2)) dut_s (
    .clock(clock), .reset(reset), .start(s_start), .abort(s_abort),
    .busy(s_busy), .done(s_done), .cfg_addr(s_cfg_addr), .cfg_rd(s_cfg_rd),
    .cfg_data(s_cfg_data), .serial_clock(s_sclk),
    .serial_data(s_sd), .serial_load(s_load)
  );

  // Storage returns junk except the cycle after a read, so mistimed capture shows up.
  always @(posedge clock) begin
    cfg_data   <= (cfg_rd && cfg_addr < NP) ? mem[cfg_addr] : CB'($urandom);
    s_cfg_data <= (s_cfg_rd && s_cfg_addr < SNP) ? s_mem[s_cfg_addr[0]] : SCB'($urandom);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time offset since the accepted start defines every output.
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  int m_t      = 0;

  always @(posedge clock) begin
    m_done = 1'b0;
    if (reset) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (abort) m_active = 1'b0;
      else if (m_t == TOTAL - 1) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end else m_t++;
    end else if (start && !abort) begin
      m_active = 1'b1;
      m_t      = 0;
    end
  end

  bit         cmp_en = 1'b0;
  int         e_pad, e_r, e_q;
  logic [5:0] e_vec, e_addr;

  always @(negedge clock) begin
    if (cmp_en) begin
      e_vec  = {m_active, m_done, 4'b0000};
      e_addr = '0;
      if (m_active) begin
        if (m_t < NP * P) begin
          e_pad = NP - 1 - m_t / P;
          e_r   = m_t % P;
          if (e_r == 0) begin
            e_vec[3] = 1'b1;
            e_addr   = 6'(e_pad);
          end else if (e_r >= 2) begin
            e_q      = e_r - 2;
            e_vec[2] = (e_q % (2 * CD)) >= CD;
            e_vec[1] = mem[e_pad][CB - 1 - e_q / (2 * CD)];
          end
        end else begin
          e_vec[0] = 1'b1;
        end
      end
      chk("outputs{busy,done,rd,sclk,sd,load}",
          {busy, done, cfg_rd, serial_clock, serial_data, serial_load}, e_vec);
      if (e_vec[3]) chk("cfg_addr", cfg_addr, e_addr);
    end
  end

  // Chain model and protocol monitor for the default instance.
  bit                mon_en = 1'b0;
  logic              prev_sclk = 1'b0, prev_sd = 1'b0, prev_busy = 1'b0, prev_load = 1'b0;
  int                edges = 0, reads = 0, busy_len = 0, last_busy_len = 0;
  int                done_cnt = 0, load_cnt = 0, exp_addr = 0;
  logic [NP*CB-1:0]  chain = '0, latched = '0;

  always @(negedge clock) begin
    if (mon_en) begin
      if (busy && !prev_busy) begin
        edges = 0; reads = 0; busy_len = 0; exp_addr = NP - 1;
      end
      if (busy) busy_len++;
      if (serial_clock && !prev_sclk) begin
        edges++;
        chain = {chain[NP*CB-2:0], serial_data};
      end
      if (serial_clock && prev_sclk) chk("sd_stable_while_sclk_high", serial_data, prev_sd);
      chk("sclk_and_load_together", serial_clock & serial_load, 1'b0);
      if (serial_load && !prev_load) begin
        latched = chain;
        load_cnt++;
      end
      if (cfg_rd) begin
        chk("rd_addr_descending", cfg_addr, exp_addr);
        exp_addr--;
        reads++;
      end
      if (done) begin
        done_cnt++;
        last_busy_len = busy_len;
        chk("edges_per_load", edges, NP * CB);
        chk("reads_per_load", reads, NP);
        for (int k = 0; k < NP; k++) chk("pad_word_after_load", latched[k*CB +: CB], mem[k]);
      end
      prev_sclk = serial_clock;
      prev_sd   = serial_data;
      prev_busy = busy;
      prev_load = serial_load;
    end
  end

  // Small-instance observation.
  bit s_bits [$];
  int cyc = 0, s_busy_len = 0, s_edge6 = -1, s_load_at = -1, s_done_cnt = 0;
  logic s_prev_sclk = 1'b0, s_prev_busy = 1'b0;

  always @(negedge clock) begin
    if (mon_en) begin
      cyc++;
      if (s_busy && !s_prev_busy) begin
        s_bits.delete(); s_busy_len = 0; s_edge6 = -1; s_load_at = -1;
      end
      if (s_busy) s_busy_len++;
      if (s_sclk && !s_prev_sclk) begin
        s_bits.push_back(s_sd);
        if (s_bits.size() == 6) s_edge6 = cyc;
      end
      if (s_load && s_load_at < 0) s_load_at = cyc;
      if (s_done) s_done_cnt++;
      s_prev_sclk = s_sclk;
      s_prev_busy = s_busy;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int maxc);
    int c;
    c = 0;
    while (!done && c < maxc) begin
      tick(1);
      c++;
    end
    chk({name, "_done_seen"}, done, 1'b1);
  endtask

  task automatic rand_mem();
    for (int k = 0; k < NP; k++) mem[k] = CB'($urandom);
  endtask

  initial begin
    int         c, dc0, lc0, rd_seen, mode;
    logic [5:0] got;
    logic [CB-1:0] w1803;

    reset = 1'b1; start = 1'b0; abort = 1'b0;
    s_start = 1'b0; s_abort = 1'b0;
    s_mem[0] = 3'b011;
    s_mem[1] = 3'b101;
    rand_mem();
    tick(3);
    chk("reset_outputs", {busy, done, cfg_rd, serial_clock, serial_data, serial_load}, 6'b0);
    chk("reset_cfg_addr", cfg_addr, 6'd0);
    chk("reset_small", {s_busy, s_done, s_cfg_rd, s_sclk, s_sd, s_load, s_cfg_addr}, 8'b0);
    reset  = 1'b0;
    mon_en = 1'b1;
    cmp_en = 1'b1;
    tick(2);

    // Small chain: pad1=101 then pad0=011 on the wire.
    s_start = 1'b1;
    tick(1);
    s_start = 1'b0;
    c = 0;
    while (!s_done && c < 40) begin tick(1); c++; end
    chk("small_done_seen", s_done, 1'b1);
    chk("small_edge_count", s_bits.size(), 6);
    got = '0;
    for (int i = 0; i < s_bits.size() && i < 6; i++) got[5-i] = s_bits[i];
    chk("small_serial_bits", got, 6'b101011);
    chk("small_busy_len", s_busy_len, 17);
    chk("small_load_after_6th_edge", s_load_at - s_edge6, 1);
    tick(3);
    chk("small_done_pulses", s_done_cnt, 1);

    // Default parameters, all pads 13'h1803.
    w1803 = pack_cfg(3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < NP; k++) mem[k] = w1803;
    pulse_start();
    wait_done("uniform", 3000);
    chk("uniform_busy_len", last_busy_len, 2054);
    chk("uniform_edges", edges, 494);
    for (int k = 0; k < NP; k++) chk("uniform_pad_1803", latched[k*CB +: CB], 13'h1803);
    tick(3);

    // Second start mid-load is ignored.
    rand_mem();
    dc0 = done_cnt;
    pulse_start();
    tick($urandom_range(100, 1500));
    pulse_start();
    wait_done("mid_start", 3000);
    tick(2);
    chk("mid_start_done_count", done_cnt - dc0, 1);
    chk("mid_start_busy_len", last_busy_len, TOTAL);
    pulse_start();
    wait_done("after_mid_start", 3000);
    tick(3);

    // Abort during pad 20 HIGH.
    rand_mem();
    pulse_start();
    c = 0;
    while (!(serial_clock && cfg_addr == 6'd20) && c < 3000) begin tick(1); c++; end
    chk("abort_point_reached", serial_clock && cfg_addr == 6'd20, 1'b1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_outputs", {busy, done, serial_clock, serial_data, serial_load}, 5'b0);
    lc0 = load_cnt;
    dc0 = done_cnt;
    tick(100);
    chk("abort_no_load", load_cnt - lc0, 0);
    chk("abort_no_done", done_cnt - dc0, 0);
    pulse_start();
    wait_done("after_abort", 3000);
    tick(3);

    // Reset in SETUP.
    rand_mem();
    pulse_start();
    c = 0;
    while (!serial_clock && c < 100) begin tick(1); c++; end
    while (serial_clock && c < 200) begin tick(1); c++; end
    chk("setup_reached", busy && !serial_clock && !cfg_rd, 1'b1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("reset_mid_outputs", {busy, done, cfg_rd, serial_clock, serial_data, serial_load, cfg_addr}, 12'b0);
    rd_seen = 0;
    repeat (50) begin
      tick(1);
      if (cfg_rd) rd_seen++;
    end
    chk("no_rd_after_reset", rd_seen, 0);
    pulse_start();
    wait_done("after_reset", 3000);
    tick(3);

    // Abort and start together in IDLE.
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_beats_start", busy, 1'b0);
    tick(3);

    // Randomized loads, aborts and ignored starts.
    repeat (6) begin
      rand_mem();
      pulse_start();
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        wait_done("rand_full", 3000);
      end else if (mode == 1) begin
        tick($urandom_range(1, 2000));
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(5);
      end else begin
        tick($urandom_range(1, 2000));
        pulse_start();
        wait_done("rand_restart", 3000);
      end
      tick($urandom_range(1, 5));
    end

    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
